// File: rtl/int_divider_seq.sv
// Sequential restoring integer divider: one quotient bit per clock, go/done handshake.
// Latency: WIDTH+1 cycles from accepted go to done (WIDTH+2 with SIGNED_DIV_EN); divide-by-zero finishes in 1 cycle.
// Backpressure: none; go is only sampled in IDLE and ignored while busy or done. Optional macro: SIGNED_DIV_EN.
module int_divider_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             err_div0
);

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2,
    S_FIX  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;        // partial remainder
  logic [WIDTH-1:0]   q_q, q_d;        // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   y_q, y_d;        // captured divisor (magnitude in signed mode)
  logic [CNT_W-1:0]   cnt_q, cnt_d;    // remaining iterations
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               err_q, err_d;
`ifdef SIGNED_DIV_EN
  logic               negq_q, negq_d;  // operand signs differ: negate quotient
  logic               negr_q, negr_d;  // dividend negative: negate remainder
`endif

  // One restoring step. The shifted remainder needs WIDTH+1 bits; when it is
  // at least the divisor the true difference is below the divisor, so the low
  // WIDTH bits of the subtraction are exact.
  logic [WIDTH:0]     r_sh;
  logic               fits;
  logic [WIDTH-1:0]   r_sub;
  logic [WIDTH-1:0]   r_next;
  logic [WIDTH-1:0]   q_next;

  // Single datapath step: shift, trial subtract, restore or keep.
  always_comb begin
    r_sh   = {r_q, q_q[WIDTH-1]};
    fits   = (r_sh >= {1'b0, y_q});
    r_sub  = r_sh[WIDTH-1:0] - y_q;
    r_next = fits ? r_sub : r_sh[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], fits};
  end

  // Next-state and register-update logic for the whole divider.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
`ifdef SIGNED_DIV_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (divisor == '0) begin
            // Divide-by-zero: report immediately, no iterations.
            quo_d   = '1;
            rem_d   = dividend;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            r_d     = '0;
`ifdef SIGNED_DIV_EN
            q_d     = dividend[WIDTH-1] ? -dividend : dividend;
            y_d     = divisor[WIDTH-1]  ? -divisor  : divisor;
            negq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            negr_d  = dividend[WIDTH-1];
`else
            q_d     = dividend;
            y_d     = divisor;
`endif
            cnt_d   = CNT_W'(WIDTH);
            err_d   = 1'b0;
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
          state_d = S_FIX;
`else
          quo_d   = q_next;
          rem_d   = r_next;
          state_d = S_DONE;
`endif
        end
      end
`ifdef SIGNED_DIV_EN
      S_FIX: begin
        // Truncation toward zero; remainder takes the dividend's sign.
        quo_d   = negq_q ? -q_q : q_q;
        rem_d   = negr_q ? -r_q : r_q;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
`ifdef SIGNED_DIV_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign err_div0  = err_q;
  assign done      = (state_q == S_DONE);
`ifdef SIGNED_DIV_EN
  assign busy      = (state_q == S_ITER) || (state_q == S_FIX);
`else
  assign busy      = (state_q == S_ITER);
`endif

endmodule
